// File: rtl/addsub_acc_pkg.sv
// Shared encodings and saturation bounds for the add/sub accumulator controller.
package addsub_acc_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic signed [16:0] ACC_MAX = 17'sd32767;
  localparam logic signed [16:0] ACC_MIN = -17'sd32768;

  function automatic logic out_of_range(input logic signed [16:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

endpackage

// File: rtl/addsub_acc_fsm.sv
// Command/response sequencer: IDLE -> EXEC -> RESP, one command in flight.
module addsub_acc_fsm
  import addsub_acc_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic cmd_valid_in,
  input  logic rsp_ready_in,
  output logic cmd_ready_out,
  output logic rsp_valid_out,
  output logic exec_out,
  output logic accept_out
);

  state_e r_state;
  logic   r_cmd_ready;
  logic   r_rsp_valid;
  logic   r_exec;

  assign accept_out    = cmd_valid_in & r_cmd_ready;
  assign cmd_ready_out = r_cmd_ready;
  assign rsp_valid_out = r_rsp_valid;
  assign exec_out      = r_exec;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_exec      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid_in) begin
          r_state     <= EXEC;
          r_cmd_ready <= 1'b0;
          r_exec      <= 1'b1;
        end
        EXEC: begin
          r_state     <= RESP;
          r_exec      <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready_in) begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_exec      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller driving an external saturating add/sub unit.
// Optional sticky saturation flag enabled by ADDSUB_ACC_SAT_FLAG_EN.
module addsub_acc_ctrl
  import addsub_acc_pkg::*;
#(
  parameter logic signed [15:0] ACC_INIT = 16'sd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [15:0] cmd_data_in,
  output logic [15:0] add_a_out,
  output logic [15:0] add_b_out,
  output logic        add_sel_out,
  input  logic [15:0] add_c_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [15:0] rsp_data_out,
  output logic        rsp_zero_out,
  output logic        rsp_neg_out,
  output logic        rsp_sat_out
);

  logic        w_accept;
  logic        w_exec;
  logic [15:0] w_acc_nxt;

  op_e         r_op;
  logic [15:0] r_data;
  logic [15:0] r_acc;
  logic        r_zero;
  logic        r_neg;

  addsub_acc_fsm u_fsm (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cmd_valid_in  (cmd_valid_in),
    .rsp_ready_in  (rsp_ready_in),
    .cmd_ready_out (cmd_ready_out),
    .rsp_valid_out (rsp_valid_out),
    .exec_out      (w_exec),
    .accept_out    (w_accept)
  );

  always_comb begin
    w_acc_nxt = r_acc;
    case (r_op)
      OP_LOAD:        w_acc_nxt = r_data;
      OP_ADD, OP_SUB: w_acc_nxt = add_c_in;
      default:        w_acc_nxt = r_acc;
    endcase
  end

  // Flags are registered together with the accumulator so the response is self-consistent.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_op   <= OP_READ;
      r_data <= '0;
      r_acc  <= ACC_INIT;
      r_zero <= (ACC_INIT == 16'sd0);
      r_neg  <= ACC_INIT[15];
    end else begin
      if (w_accept) begin
        r_op   <= op_e'(cmd_op_in);
        r_data <= cmd_data_in;
      end
      if (w_exec) begin
        r_acc  <= w_acc_nxt;
        r_zero <= (w_acc_nxt == 16'd0);
        r_neg  <= w_acc_nxt[15];
      end
    end
  end

  assign add_a_out    = r_acc;
  assign add_b_out    = r_data;
  assign add_sel_out  = w_exec && (r_op == OP_SUB);
  assign rsp_data_out = r_acc;
  assign rsp_zero_out = r_zero;
  assign rsp_neg_out  = r_neg;

`ifdef ADDSUB_ACC_SAT_FLAG_EN
  logic signed [16:0] w_shadow;
  logic               r_sat;

  // Unsaturated 17-bit result reveals whether the adder clipped.
  assign w_shadow = (r_op == OP_SUB) ? ({r_acc[15], r_acc} - {r_data[15], r_data})
                                     : ({r_acc[15], r_acc} + {r_data[15], r_data});

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sat <= 1'b0;
    end else if (w_exec) begin
      case (r_op)
        OP_LOAD:        r_sat <= 1'b0;
        OP_ADD, OP_SUB: if (out_of_range(w_shadow)) r_sat <= 1'b1;
        default:        r_sat <= r_sat;
      endcase
    end
  end

  assign rsp_sat_out = r_sat;
`else
  assign rsp_sat_out = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl with a behavioural saturating adder.
module tb_addsub_acc_ctrl;

`ifdef ADDSUB_ACC_SAT_FLAG_EN
  localparam bit SATX = 1'b1;
`else
  localparam bit SATX = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in;
  logic [15:0] cmd_data_in;
  logic [15:0] add_a_out;
  logic [15:0] add_b_out;
  logic        add_sel_out;
  logic [15:0] add_c_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [15:0] rsp_data_out;
  logic        rsp_zero_out;
  logic        rsp_neg_out;
  logic        rsp_sat_out;

  int n_chk = 0;
  int n_err = 0;

  addsub_acc_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_op_in     (cmd_op_in),
    .cmd_data_in   (cmd_data_in),
    .add_a_out     (add_a_out),
    .add_b_out     (add_b_out),
    .add_sel_out   (add_sel_out),
    .add_c_in      (add_c_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_data_out  (rsp_data_out),
    .rsp_zero_out  (rsp_zero_out),
    .rsp_neg_out   (rsp_neg_out),
    .rsp_sat_out   (rsp_sat_out)
  );

  always #5 clk_in = ~clk_in;

  // External saturating adder.
  logic signed [16:0] m_s;
  always_comb begin
    m_s = add_sel_out ? ($signed({add_a_out[15], add_a_out}) - $signed({add_b_out[15], add_b_out}))
                      : ($signed({add_a_out[15], add_a_out}) + $signed({add_b_out[15], add_b_out}));
    if (m_s > 17'sd32767)       add_c_in = 16'h7FFF;
    else if (m_s < -17'sd32768) add_c_in = 16'h8000;
    else                        add_c_in = m_s[15:0];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. while the command is in EXEC.
  task automatic send(input logic [1:0] op, input logic [15:0] d, input string tag);
    bit done;
    done = 1'b0;
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    cmd_data_in  = d;
    for (int i = 0; i < 10 && !done; i++) begin
      if (cmd_ready_out) done = 1'b1;
      tick();
    end
    cmd_valid_in = 1'b0;
    chk({tag, "_accept"}, {31'd0, done}, 32'd1);
  endtask

  task automatic get_rsp(input string tag, input logic [15:0] ed, input bit ez, input bit en, input bit es);
    tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid_out}, 32'd1);
    chk({tag, "_data"}, {16'd0, rsp_data_out}, {16'd0, ed});
    chk({tag, "_flags"}, {29'd0, rsp_zero_out, rsp_neg_out, rsp_sat_out}, {29'd0, ez, en, es});
    rsp_ready_in = 1'b1;
    tick();
    rsp_ready_in = 1'b0;
    chk({tag, "_idle"}, {30'd0, rsp_valid_out, cmd_ready_out}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, {30'd0, cmd_ready_out, rsp_valid_out}, 32'd2);
    chk({tag, "_data"}, {16'd0, rsp_data_out}, 32'd0);
    chk({tag, "_flags"}, {29'd0, rsp_zero_out, rsp_neg_out, rsp_sat_out}, 32'd4);
    chk({tag, "_adder"}, {add_sel_out, add_a_out, add_b_out}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in       = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_op_in    = 2'b00;
    cmd_data_in  = 16'd0;
    rsp_ready_in = 1'b0;
    #1 rst_in = 1'b1;
    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    rst_in = 1'b0;
    tick();

    // Basic load/add.
    send(2'b01, 16'd100, "ld100");
    get_rsp("ld100", 16'd100, 0, 0, 0);
    send(2'b10, 16'd50, "add50");
    get_rsp("add50", 16'd150, 0, 0, 0);

    // Positive saturation, then READ keeps sticky flag.
    send(2'b01, 16'd32000, "ld32000");
    get_rsp("ld32000", 16'd32000, 0, 0, 0);
    send(2'b10, 16'd1000, "add1000");
    get_rsp("add1000", 16'h7FFF, 0, 0, SATX);
    send(2'b00, 16'd0, "read1");
    get_rsp("read1", 16'h7FFF, 0, 0, SATX);

    // Negative saturation, LOAD clears the flag.
    send(2'b01, 16'h8000, "ldmin");
    get_rsp("ldmin", 16'h8000, 0, 1, 0);
    send(2'b11, 16'd1, "sub1");
    get_rsp("sub1", 16'h8000, 0, 1, SATX);
    send(2'b01, 16'd0, "ld0");
    get_rsp("ld0", 16'd0, 1, 0, 0);

    // 0 - (-32768) saturates high; adder drive during EXEC.
    send(2'b01, 16'd0, "ld0b");
    get_rsp("ld0b", 16'd0, 1, 0, 0);
    send(2'b11, 16'h8000, "submin");
    chk("submin_exec", {add_sel_out, add_b_out, add_a_out[14:0]}, {1'b1, 16'h8000, 15'd0});
    get_rsp("submin", 16'h7FFF, 0, 0, SATX);

    // Backpressure: response held, competing command refused.
    send(2'b01, 16'd7, "ld7");
    get_rsp("ld7", 16'd7, 0, 0, 0);
    send(2'b10, 16'hFFF6, "addm10");
    tick();
    chk("bp_valid", {31'd0, rsp_valid_out}, 32'd1);
    cmd_valid_in = 1'b1;
    cmd_op_in    = 2'b01;
    cmd_data_in  = 16'd99;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", {12'd0, rsp_valid_out, cmd_ready_out, rsp_zero_out, rsp_neg_out, rsp_data_out},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFD});
      tick();
    end
    cmd_valid_in = 1'b0;
    rsp_ready_in = 1'b1;
    tick();
    rsp_ready_in = 1'b0;
    send(2'b00, 16'd0, "read2");
    get_rsp("read2", 16'hFFFD, 0, 1, 0);

    // Reset during EXEC drops the command.
    send(2'b01, 16'd10, "ld10");
    get_rsp("ld10", 16'd10, 0, 0, 0);
    send(2'b10, 16'd5, "add5");
    rst_in = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_in = 1'b0;
    tick();
    tick();
    chk("midrst_norsp", {31'd0, rsp_valid_out}, 32'd0);
    send(2'b00, 16'd0, "read3");
    get_rsp("read3", 16'd0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
